// File: rtl/io_input_conditioner.sv
// Board SW/KEY conditioning: 2-flop sync, per-channel debounce, sticky per-key press flags.
// Optional auto-repeat of key press events when IOCOND_AUTOREPEAT_EN is defined.

module io_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter bit INVERT          = 1'b0
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic raw,
  output logic q
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_STABLE, ST_COUNTING} state_t;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  state_t        state;

  // Keys are inverted on entry so the idle (released) pin resets to 0 here too.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) sync <= '0;
    else         sync <= {sync[0], raw ^ INVERT};
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state <= ST_STABLE;
      cnt   <= '0;
      q     <= 1'b0;
    end else begin
      case (state)
        ST_STABLE: begin
          if (sync[1] != q) begin
            if (cnt == LAST) q <= sync[1];
            else begin
              state <= ST_COUNTING;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        ST_COUNTING: begin
          if (sync[1] == q) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            q     <= sync[1];
            state <= ST_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

module io_input_conditioner #(
  parameter int N_SW            = 10,
  parameter int N_KEY           = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_SW-1:0]  i_sw,
  input  logic [N_KEY-1:0] i_key_n,
  input  logic             i_evt_clr,
  input  logic [N_KEY-1:0] i_evt_clr_mask,
  output logic [N_SW-1:0]  o_sw,
  output logic [N_KEY-1:0] o_key,
  output logic [N_KEY-1:0] o_key_press,
  output logic [31:0]      o_io_sw
);
  logic [N_KEY-1:0] key_d;
  logic [N_KEY-1:0] rpt_evt;
  logic [N_KEY-1:0] press_evt;
  logic [N_KEY-1:0] clr_sel;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    io_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b0)) u_ch (
      .gclk(i_clk), .grst_n(i_reset), .raw(i_sw[i]), .q(o_sw[i])
    );
  end

  for (genvar k = 0; k < N_KEY; k++) begin : g_key
    io_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b1)) u_ch (
      .gclk(i_clk), .grst_n(i_reset), .raw(i_key_n[k]), .q(o_key[k])
    );
  end

`ifdef IOCOND_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_NEXT  = RW'(REPEAT_PERIOD - 1);

  for (genvar k = 0; k < N_KEY; k++) begin : g_rpt
    logic [RW-1:0] rpt_cnt;
    logic          first;

    // First repeat waits REPEAT_DELAY after acceptance, later ones REPEAT_PERIOD.
    assign rpt_evt[k] = o_key[k] && (rpt_cnt == (first ? R_FIRST : R_NEXT));

    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        rpt_cnt <= '0;
        first   <= 1'b1;
      end else if (!o_key[k]) begin
        rpt_cnt <= '0;
        first   <= 1'b1;
      end else if (rpt_evt[k]) begin
        rpt_cnt <= '0;
        first   <= 1'b0;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  assign rpt_evt = '0;
`endif

  assign press_evt = (o_key & ~key_d) | rpt_evt;
  assign clr_sel   = i_evt_clr ? i_evt_clr_mask : '0;

  // Set beats clear so a press landing on a software clear is never lost.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      key_d       <= '0;
      o_key_press <= '0;
    end else begin
      key_d       <= o_key;
      o_key_press <= press_evt | (o_key_press & ~clr_sel);
    end
  end

  always_comb begin
    o_io_sw = '0;
    o_io_sw[N_SW-1:0]                  = o_sw;
    o_io_sw[N_SW+N_KEY-1:N_SW]         = o_key;
    o_io_sw[N_SW+2*N_KEY-1:N_SW+N_KEY] = o_key_press;
  end
endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner at DEBOUNCE_CYCLES=4 (repeat 10/5 when enabled).
module tb_io_input_conditioner;
  logic        clk;
  logic        rst_n;
  logic [9:0]  sw;
  logic [3:0]  key_n;
  logic        evt_clr;
  logic [3:0]  evt_clr_mask;
  logic [9:0]  o_sw;
  logic [3:0]  o_key;
  logic [3:0]  o_key_press;
  logic [31:0] o_io_sw;

  int n_vec = 0;
  int n_err = 0;

  io_input_conditioner #(
    .N_SW(10), .N_KEY(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_sw(sw), .i_key_n(key_n),
    .i_evt_clr(evt_clr), .i_evt_clr_mask(evt_clr_mask),
    .o_sw(o_sw), .o_key(o_key), .o_key_press(o_key_press), .o_io_sw(o_io_sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw = '0; key_n = 4'hF; evt_clr = 1'b0; evt_clr_mask = '0;
    tick(); tick();
    n_vec++;
    if (o_io_sw !== 32'h0) begin
      n_err++; $display("FAIL reset_held io_sw got %h want %h", o_io_sw, 32'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (o_io_sw !== 32'h0) begin
        n_err++; $display("FAIL reset_idle[%0d] io_sw got %h want %h", i, o_io_sw, 32'h0);
      end
    end
  endtask

  task automatic test_sw_latency();
    sw = 10'h001;
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_vec++;
      if (o_sw !== ((e == 6) ? 10'h001 : 10'h000)) begin
        n_err++; $display("FAIL sw_latency edge%0d o_sw got %h want %h", e, o_sw, (e == 6) ? 10'h001 : 10'h000);
      end
    end
    n_vec++;
    if (o_io_sw !== 32'h0000_0001) begin
      n_err++; $display("FAIL sw_io_word got %h want %h", o_io_sw, 32'h0000_0001);
    end
  endtask

  task automatic test_glitch();
    key_n = 4'hE;
    tick(); tick(); tick();
    key_n = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (o_key !== 4'h0 || o_key_press !== 4'h0) begin
        n_err++; $display("FAIL glitch[%0d] key/press got %h/%h want 0/0", i, o_key, o_key_press);
      end
    end
  endtask

  // Low for exactly DEBOUNCE_CYCLES samples is the shortest accepted press.
  task automatic test_boundary();
    key_n = 4'hB;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 4) key_n = 4'hF;
    end
    n_vec++;
    if (o_key !== 4'h4) begin
      n_err++; $display("FAIL boundary_accept o_key got %h want %h", o_key, 4'h4);
    end
    tick();
    n_vec++;
    if (o_key_press !== 4'h4) begin
      n_err++; $display("FAIL boundary_flag got %h want %h", o_key_press, 4'h4);
    end
    repeat (8) tick();
    evt_clr = 1'b1; evt_clr_mask = 4'h4;
    tick();
    evt_clr = 1'b0; evt_clr_mask = 4'h0;
    n_vec++;
    if (o_key !== 4'h0 || o_key_press !== 4'h0) begin
      n_err++; $display("FAIL boundary_cleanup key/press got %h/%h want 0/0", o_key, o_key_press);
    end
  endtask

  task automatic test_press_clear();
    key_n = 4'hE;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) begin
        n_vec++;
        if (o_key !== 4'h0) begin
          n_err++; $display("FAIL press_early o_key got %h want %h", o_key, 4'h0);
        end
      end
    end
    n_vec++;
    if (o_key !== 4'h1 || o_key_press !== 4'h0) begin
      n_err++; $display("FAIL press_accept key/press got %h/%h want 1/0", o_key, o_key_press);
    end
    tick();
    n_vec++;
    if (o_io_sw !== 32'h0000_4401) begin
      n_err++; $display("FAIL press_flag io_sw got %h want %h", o_io_sw, 32'h0000_4401);
    end
    repeat (13) tick();
    key_n = 4'hF;
    repeat (8) tick();
    n_vec++;
    if (o_io_sw !== 32'h0000_4001) begin
      n_err++; $display("FAIL release_keeps_flag io_sw got %h want %h", o_io_sw, 32'h0000_4001);
    end
    evt_clr = 1'b1; evt_clr_mask = 4'b0001;
    tick();
    evt_clr = 1'b0; evt_clr_mask = 4'h0;
    n_vec++;
    if (o_key_press !== 4'h0 || o_io_sw !== 32'h0000_0001) begin
      n_err++; $display("FAIL press_clear press/io got %h/%h want 0/%h", o_key_press, o_io_sw, 32'h0000_0001);
    end
  endtask

  task automatic test_set_wins();
    key_n = 4'hE;
    repeat (6) tick();
    evt_clr = 1'b1; evt_clr_mask = 4'b0001;
    tick();
    evt_clr = 1'b0; evt_clr_mask = 4'h0;
    n_vec++;
    if (o_key_press !== 4'h1) begin
      n_err++; $display("FAIL set_wins got %h want %h", o_key_press, 4'h1);
    end
    evt_clr = 1'b1; evt_clr_mask = 4'b0010;
    tick();
    evt_clr = 1'b0; evt_clr_mask = 4'h0;
    n_vec++;
    if (o_key_press !== 4'h1) begin
      n_err++; $display("FAIL clr_other_mask got %h want %h", o_key_press, 4'h1);
    end
    tick();
    n_vec++;
    if (o_key_press !== 4'h1) begin
      n_err++; $display("FAIL no_retrigger_while_held got %h want %h", o_key_press, 4'h1);
    end
    key_n = 4'hF;
    repeat (8) tick();
    evt_clr = 1'b1; evt_clr_mask = 4'hF;
    tick();
    evt_clr = 1'b0; evt_clr_mask = 4'h0;
    n_vec++;
    if (o_key_press !== 4'h0) begin
      n_err++; $display("FAIL set_wins_cleanup got %h want %h", o_key_press, 4'h0);
    end
  endtask

  task automatic test_reset_mid();
    key_n = 4'h7;
    repeat (7) tick();
    n_vec++;
    if (o_key !== 4'h8 || o_key_press !== 4'h8) begin
      n_err++; $display("FAIL mid_pre key/press got %h/%h want 8/8", o_key, o_key_press);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_io_sw !== 32'h0) begin
      n_err++; $display("FAIL mid_reset io_sw got %h want %h", o_io_sw, 32'h0);
    end
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) begin
        n_vec++;
        if (o_key !== 4'h0) begin
          n_err++; $display("FAIL mid_relatency edge5 o_key got %h want %h", o_key, 4'h0);
        end
      end
      if (e == 6) begin
        n_vec++;
        if (o_key !== 4'h8 || o_key_press !== 4'h0) begin
          n_err++; $display("FAIL mid_reaccept key/press got %h/%h want 8/0", o_key, o_key_press);
        end
      end
    end
    n_vec++;
    if (o_io_sw !== 32'h0002_2001) begin
      n_err++; $display("FAIL mid_fresh_flag io_sw got %h want %h", o_io_sw, 32'h0002_2001);
    end
    key_n = 4'hF;
    repeat (8) tick();
    evt_clr = 1'b1; evt_clr_mask = 4'hF;
    tick();
    evt_clr = 1'b0; evt_clr_mask = 4'h0;
  endtask

`ifdef IOCOND_AUTOREPEAT_EN
  task automatic test_autorepeat();
    logic exp;
    key_n = 4'hD;
    repeat (6) tick();
    n_vec++;
    if (o_key !== 4'h2) begin
      n_err++; $display("FAIL rpt_accept o_key got %h want %h", o_key, 4'h2);
    end
    for (int k = 1; k <= 22; k++) begin
      tick();
      evt_clr = 1'b0; evt_clr_mask = 4'h0;
      exp = (k == 1 || k == 10 || k == 15 || k == 20);
      n_vec++;
      if (o_key_press[1] !== exp) begin
        n_err++; $display("FAIL rpt_flag k=%0d got %b want %b", k, o_key_press[1], exp);
      end
      if (o_key_press[1]) begin
        evt_clr = 1'b1; evt_clr_mask = 4'b0010;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_io_sw !== 32'h0) begin
      n_err++; $display("FAIL rpt_reset io_sw got %h want %h", o_io_sw, 32'h0);
    end
    evt_clr = 1'b0; evt_clr_mask = 4'h0; key_n = 4'hF;
    tick();
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_sw_latency();
    test_glitch();
    test_boundary();
    test_press_clear();
    test_set_wins();
    test_reset_mid();
`ifdef IOCOND_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
Conditions the raw DE10-Standard SW and KEY inputs before they reach the single_cycle core's i_io_sw port. Every bit is synchronised into the core clock domain and debounced by a per-channel counter. KEYs are converted to active-high. Per-KEY press events are latched as sticky flags that software clears, so short presses are never lost to polling latency. It sits between the board pins and single_cycle, replacing the direct {18'd0, ~KEY, SW} mapping.

Parameters:
N_SW, 10, number of slide switches.
N_KEY, 4, number of push buttons (raw, active-low).
DEBOUNCE_CYCLES, 100000, consecutive stable cycles needed to accept a new level (10 ms at 10 MHz); legal range ≥1.
REPEAT_DELAY, 5000000, cycles a key must be held before the first auto-repeat (only with the optional feature).
REPEAT_PERIOD, 1000000, cycles between auto-repeats (only with the optional feature).

Ports:
i_clk  in  1  core clock (10 MHz divided clock)
i_reset  in  1  asynchronous active-low reset
i_sw  in  N_SW  raw switches, asynchronous
i_key_n  in  N_KEY  raw keys, active-low, asynchronous
i_evt_clr  in  1  one-cycle strobe; clears the sticky flags selected by i_evt_clr_mask
i_evt_clr_mask  in  N_KEY  per-key clear select, sampled only when i_evt_clr=1
o_sw  out  N_SW  debounced switch levels
o_key  out  N_KEY  debounced key levels, active-high (1 = pressed)
o_key_press  out  N_KEY  sticky press-event flags
o_io_sw  out  32  packed word for single_cycle: [N_SW-1:0]=o_sw, [N_SW+N_KEY-1:N_SW]=o_key, [N_SW+2*N_KEY-1:N_SW+N_KEY]=o_key_press, remaining bits 0 (defaults: [9:0], [13:10], [17:14], [31:18]=0)

Behaviour:
- Reset (i_reset=0, asynchronous): sync flops idle (sw=0, key_n=1); all counters 0; o_sw=0, o_key=0, o_key_press=0, o_io_sw=0. Outputs are registered and stay at these values until the debounce logic accepts a change.
- Synchroniser: 2-flop chain per bit. The key chain holds the inverted level, so internal key data is active-high.
- Per-channel debounce FSM:
  - STABLE: synced == stable → counter held at 0.
  - synced != stable → COUNTING, counter increments once per cycle.
  - In COUNTING, if synced returns to match stable → STABLE, counter cleared (glitch rejected).
  - When the counter equals DEBOUNCE_CYCLES-1 and synced still differs → stable <= synced, counter <= 0, return to STABLE.
  - The counter width is $clog2(DEBOUNCE_CYCLES+1). It never wraps.
- Latency: a clean input edge appears on o_sw/o_key exactly 2+DEBOUNCE_CYCLES rising clock edges after the first edge that samples it. With DEBOUNCE_CYCLES=1 this is 3 edges.
- Sticky flags:
  - o_key_press[k] sets on the cycle after debounced o_key[k] goes 0→1.
  - It clears when i_evt_clr=1 and i_evt_clr_mask[k]=1.
  - A set and a clear on the same bit in the same cycle → set wins (flag=1).
  - Release (1→0) never changes a flag.
  - A flag that is already set stays 1 on a new press; there is no counting.
- o_io_sw is combinational from the registered outputs, so it adds no extra latency.
- Mid-operation reset immediately forces all outputs to 0 and discards any partial count. After release, a held key reappears after the full latency and produces a fresh press flag.

Optional Feature:
Macro IOCOND_AUTOREPEAT_EN.
- Defined: each key gets a repeat counter that runs while debounced o_key[k]=1.
  - At REPEAT_DELAY cycles after the press is accepted, the internal press event fires again (sets o_key_press[k]), the counter reloads, and it then fires every REPEAT_PERIOD cycles.
  - The counter resets to 0 on release or reset.
  - Set-wins priority over i_evt_clr applies to repeat events too.
- Undefined: no repeat counters are synthesised; exactly one event per debounced press.

Test Plan:
1. Reset with i_key_n=4'hF, i_sw=0; release reset → o_io_sw=32'h0 for all subsequent cycles.
2. DEBOUNCE_CYCLES=4; i_sw=10'h001 applied cleanly → o_sw=10'h001 exactly 6 edges later, o_io_sw=32'h0000_0001.
3. DEBOUNCE_CYCLES=4; KEY0 pulses low for 3 cycles then returns high → o_key stays 0 and o_key_press stays 0.
4. DEBOUNCE_CYCLES=4; KEY0 held low 20 cycles then released → o_key[0]=1 after 6 edges; o_key_press[0]=1 one cycle later and stays 1 after release; o_io_sw[14]=1. Then i_evt_clr=1 with mask=4'b0001 → o_key_press[0]=0 next cycle.
5. Press-edge set coincides with i_evt_clr on the same key → o_key_press=1 (set wins). Clear with mask=4'b0010 while flag 0 is set → flag 0 stays 1.
6. With IOCOND_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5: hold KEY1 and clear its flag each cycle it sets → flag reasserts 10 cycles after acceptance, then every 5 cycles. Assert reset while held → outputs 0 immediately.
